sqi_mem_responder: RTL and testbench
====================================

Name: sqi_mem_responder

Overview:
Synthesizable SQI (quad-SPI) memory responder: the target side of the core's SQI initiator bus (sck, active-low cs, 4-bit data). It decodes read/write commands clocked in on sck, drives read data back, and accesses a byte-wide backing store through a simple synchronous port. It is used as the memory model in the top-level bench and as a loopback target on the FPGA build.

Parameters:
ADDR_W, 16, backing-store address width; the low ADDR_W bits of the 24-bit bus address are used, upper bits ignored
DUMMY_NIB, 2, dummy nibbles between address and first read data nibble

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sqi_sck  input  1  SQI serial clock from initiator, synchronous to clk
sqi_cs  input  1  chip select, active low
sqi_data_in  input  4  data from initiator
sqi_data_out  output  4  data to initiator
sqi_data_oe  output  1  1 = responder drives sqi_data_out
mem_addr  output  ADDR_W  backing-store byte address
mem_re  output  1  read strobe, one clk pulse
mem_rdata  input  8  read data, valid the clk cycle after mem_re
mem_we  output  1  write strobe, one clk pulse
mem_wdata  output  8  write data, valid with mem_we
cmd_err  output  1  sticky: unsupported command seen in the current transaction

Behaviour:
- Reset values: sqi_data_out=0, sqi_data_oe=0, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, cmd_err=0, state IDLE.
- sck_q registers sqi_sck; rise = sck & ~sck_q, fall = ~sck & sck_q. sck high and low phases are each ≥2 clk.
- Nibble order is MSB first; a byte is two nibbles, high nibble first.
- States: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
- IDLE: sqi_cs low -> CMD, clear nibble counter, clear cmd_err.
- CMD: sample sqi_data_in on 2 rises. Byte 0x03 (read) or 0x02 (write) -> ADDR; any other byte -> IGNORE and set cmd_err.
- ADDR: 6 nibbles on rises form a 24-bit address; mem_addr = addr[ADDR_W-1:0]. On the 6th rise: read -> pulse mem_re, go to DUMMY; write -> WRITE.
- DUMMY: count DUMMY_NIB rises. Capture mem_rdata into the shift register the cycle after mem_re. After the last dummy rise -> READ.
- READ: sqi_data_oe=1. On each fall, drive the next nibble (high, then low). Falls that precede the first READ state do not drive. After the low nibble is driven: mem_addr+1 (wraps 2^ADDR_W-1 -> 0), pulse mem_re, and capture the next byte the following cycle.
- WRITE: sample nibbles on rises. On every 2nd nibble: mem_wdata = byte, pulse mem_we with the current mem_addr, then increment mem_addr the next cycle (same wrap rule).
- IGNORE: no memory access, oe=0, until cs rises.
- sqi_cs high in any state: next clk -> IDLE, sqi_data_oe=0 that same cycle, counters cleared. A partial write byte (odd nibble count) is discarded with no mem_we. cmd_err holds until the next cs fall.
- rise coincident with cs going high: the edge is ignored.
- mem_re and mem_we are never asserted in the same cycle.
- Async reset mid-transaction: all outputs go to reset values immediately; the next transaction must start with a fresh cs fall.

Test Plan:
- Write: cs low, nibbles 0,2 | 0,0,0,1,0,0 | A,5,3,C, cs high -> mem_we pulses: (0x0100, 0xA5) then (0x0101, 0x3C); no third pulse.
- Read: store[0x0100]=0xA5, store[0x0101]=0x3C; send 0x03, addr 0x000100, 2 dummy nibbles, 4 more clocks -> sqi_data_out on successive falls reads A,5,3,C; sqi_data_oe=1 only during READ.
- Wrap: read from addr 0x00FFFF with ADDR_W=16, 2 bytes -> mem_re at 0xFFFF then 0x0000; upper address byte 0x12 is ignored (same result).
- Bad command 0x9F -> cmd_err=1, no mem_re/mem_we, oe stays 0. After cs high then a new valid read -> cmd_err=0.
- Abort: write 0x02, addr 0x000010, 3 data nibbles, cs high -> exactly one mem_we (0x0010) and sqi_data_oe=0. Then assert rst_n=0 mid-read -> sqi_data_oe=0 immediately and state IDLE.

Source files
------------

// File: rtl/sqi_mem_responder_if.sv
// sqi_mem_responder_if: SQI target pins plus the byte-wide backing-store port.
interface sqi_mem_responder_if #(parameter int ADDR_W = 16) ();
  logic              sqi_sck;
  logic              sqi_cs;
  logic [3:0]        sqi_data_in;
  logic [3:0]        sqi_data_out;
  logic              sqi_data_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              cmd_err;
  modport slave (
    input  sqi_sck, sqi_cs, sqi_data_in, mem_rdata,
    output sqi_data_out, sqi_data_oe, mem_addr, mem_re, mem_we, mem_wdata, cmd_err
  );
  modport master (
    output sqi_sck, sqi_cs, sqi_data_in, mem_rdata,
    input  sqi_data_out, sqi_data_oe, mem_addr, mem_re, mem_we, mem_wdata, cmd_err
  );
endinterface

// File: rtl/sqi_mem_responder.sv
// sqi_mem_responder: SQI (quad-SPI) memory target decoding read/write commands
// into single-cycle strobes on a byte-wide synchronous backing store.
module sqi_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int DUMMY_NIB = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sqi_mem_responder_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;
  state_t            r_state, w_nxt;
  logic              r_sck_q, r_rd, r_re, r_we, r_cap, r_winc, r_err;
  logic [2:0]        r_cnt;
  logic [3:0]        r_nib, r_dout;
  logic [ADDR_W-5:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr, w_addr;
  logic [7:0]        r_rdbuf, r_wdata, w_byte;
  logic              w_rise, w_fall, w_step, w_last_cmd, w_cmd_ok, w_last_addr;
  logic              w_dummy_done, w_wr_byte, w_rd_hi, w_rd_lo;
  // edges coincident with cs high are dropped
  assign w_rise       = bus.sqi_sck & ~r_sck_q & ~bus.sqi_cs;
  assign w_fall       = ~bus.sqi_sck & r_sck_q & ~bus.sqi_cs;
  assign w_step       = (r_state == READ) ? w_fall : w_rise;
  assign w_byte       = {r_nib, bus.sqi_data_in};
  assign w_addr       = {r_addr, bus.sqi_data_in};
  assign w_cmd_ok     = (w_byte == 8'h03) || (w_byte == 8'h02);
  assign w_last_cmd   = (r_state == CMD) && w_rise && (r_cnt == 3'd1);
  assign w_last_addr  = (r_state == ADDR) && w_rise && (r_cnt == 3'd5);
  assign w_dummy_done = (r_state == DUMMY) && w_rise && (r_cnt == 3'(DUMMY_NIB - 1));
  assign w_wr_byte    = (r_state == WRITE) && w_rise && r_cnt[0];
  assign w_rd_hi      = (r_state == READ) && w_fall && !r_cnt[0];
  assign w_rd_lo      = (r_state == READ) && w_fall && r_cnt[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = r_state;
    if (bus.sqi_cs) w_nxt = IDLE;
    else if (r_state == IDLE) w_nxt = CMD;
    else if (w_last_cmd) w_nxt = w_cmd_ok ? ADDR : IGNORE;
    else if (w_last_addr) w_nxt = r_rd ? DUMMY : WRITE;
    else if (w_dummy_done) w_nxt = READ;
  end
  always_comb begin
    bus.sqi_data_oe  = (r_state == READ) && !bus.sqi_cs;
    bus.sqi_data_out = r_dout;
    bus.mem_addr     = r_mem_addr;
    bus.mem_re       = r_re;
    bus.mem_we       = r_we;
    bus.mem_wdata    = r_wdata;
    bus.cmd_err      = r_err;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_q <= 1'b0; r_rd <= 1'b0; r_re <= 1'b0; r_we <= 1'b0;
      r_cap <= 1'b0; r_winc <= 1'b0; r_err <= 1'b0; r_cnt <= '0;
      r_nib <= '0; r_dout <= '0; r_addr <= '0; r_mem_addr <= '0;
      r_rdbuf <= '0; r_wdata <= '0;
    end else begin
      r_sck_q <= bus.sqi_sck;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_cap   <= r_re;
      r_winc  <= w_wr_byte;
      r_cnt   <= (w_nxt != r_state) ? 3'd0 : r_cnt + {2'b00, w_step};
      if (w_rise) r_nib <= bus.sqi_data_in;
      if (r_state == IDLE && w_nxt == CMD) r_err <= 1'b0;
      else if (w_last_cmd && !w_cmd_ok) r_err <= 1'b1;
      if (w_last_cmd) r_rd <= (w_byte == 8'h03);
      if (r_state == ADDR && w_rise) r_addr <= w_addr[ADDR_W-5:0];
      if (w_last_addr) begin
        r_mem_addr <= w_addr;
        r_re       <= r_rd;
      end
      if (r_cap) r_rdbuf <= bus.mem_rdata;
      if (w_rd_hi) r_dout <= r_rdbuf[7:4];
      // finishing a byte prefetches the next one so it is ready before the next fall
      if (w_rd_lo) begin
        r_dout     <= r_rdbuf[3:0];
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
        r_re       <= 1'b1;
      end
      if (w_wr_byte) begin
        r_wdata <= w_byte;
        r_we    <= 1'b1;
      end
      if (r_winc) r_mem_addr <= r_mem_addr + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_sqi_mem_responder.sv
// tb_sqi_mem_responder: directed SQI transactions with a queue-based scoreboard
// checking memory strobes and read nibbles as the responder produces them.
module tb_sqi_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sqi_mem_responder_if #(.ADDR_W(16)) bus ();
  sqi_mem_responder #(.ADDR_W(16), .DUMMY_NIB(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {byte kind; logic [15:0] addr; logic [7:0] data;} ev_t;
  ev_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] store [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) store[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= store[bus.mem_addr];
  end
  task automatic push(input byte k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endtask
  task automatic pop_cmp(input string nm, input byte k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s unexpected: addr=%h data=%h", nm, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        n_bad++;
        $display("FAIL %s: got %s addr=%h data=%h, want %s addr=%h data=%h",
                 nm, string'(k), a, d, string'(e.kind), e.addr, e.data);
      end
    end
  endtask
  logic m_sck_q = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) pop_cmp("mem_we", "W", bus.mem_addr, bus.mem_wdata);
      if (bus.mem_re) pop_cmp("mem_re", "R", bus.mem_addr, 8'h00);
      if (bus.sqi_sck && !m_sck_q && !bus.sqi_cs && bus.sqi_data_oe)
        pop_cmp("rd_nibble", "N", 16'h0000, {4'h0, bus.sqi_data_out});
    end
    m_sck_q = bus.sqi_sck;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic sck_cyc(input logic [3:0] d);
    bus.sqi_sck = 1'b0; bus.sqi_data_in = d;
    clks(3);
    bus.sqi_sck = 1'b1;
    clks(3);
  endtask
  task automatic send_byte(input logic [7:0] b);
    sck_cyc(b[7:4]);
    sck_cyc(b[3:0]);
  endtask
  task automatic cs_lo();
    bus.sqi_cs = 1'b0;
    clks(2);
  endtask
  task automatic cs_hi();
    bus.sqi_cs = 1'b1;
    clks(3);
  endtask
  task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
    cs_lo();
    send_byte(c);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask
  task automatic do_write(input logic [23:0] a, input logic [15:0] ea, input logic [7:0] b0,
                          input logic [7:0] b1, input int nn);
    logic [15:0] d;
    d = {b0, b1};
    if (nn >= 2) push("W", ea, b0);
    if (nn >= 4) push("W", ea + 16'd1, b1);
    send_hdr(8'h02, a);
    for (int i = 0; i < nn; i++) sck_cyc(d[15-4*i -: 4]);
  endtask
  task automatic do_read(input logic [23:0] a, input logic [15:0] ea, input logic [7:0] b0,
                         input logic [7:0] b1, input int nb);
    push("R", ea, 8'h00);
    push("N", 16'h0000, {4'h0, b0[7:4]});
    if (nb >= 2) begin push("R", ea + 16'd1, 8'h00); push("N", 16'h0000, {4'h0, b0[3:0]}); end
    if (nb >= 3) push("N", 16'h0000, {4'h0, b1[7:4]});
    if (nb >= 4) begin push("R", ea + 16'd2, 8'h00); push("N", 16'h0000, {4'h0, b1[3:0]}); end
    send_hdr(8'h03, a);
    repeat (2) sck_cyc(4'h0);
    repeat (nb) sck_cyc(4'hF);
  endtask
  initial begin
    bus.sqi_sck = 1'b1; bus.sqi_cs = 1'b1; bus.sqi_data_in = 4'h0;
    clks(3);
    chk("rst_oe", {31'd0, bus.sqi_data_oe}, 32'd0);
    chk("rst_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
    chk("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_err_dout", {27'd0, bus.cmd_err, bus.sqi_data_out}, 32'd0);
    rst_n = 1'b1;
    clks(3);
    do_write(24'h000100, 16'h0100, 8'hA5, 8'h3C, 4);
    cs_hi();
    do_read(24'h000100, 16'h0100, 8'hA5, 8'h3C, 4);
    chk("oe_in_read", {31'd0, bus.sqi_data_oe}, 32'd1);
    cs_hi();
    chk("oe_after_read", {31'd0, bus.sqi_data_oe}, 32'd0);
    do_write(24'h00FFFF, 16'hFFFF, 8'h77, 8'h88, 4);
    cs_hi();
    do_read(24'h00FFFF, 16'hFFFF, 8'h77, 8'h88, 4);
    cs_hi();
    do_read(24'h12FFFF, 16'hFFFF, 8'h77, 8'h88, 4);
    cs_hi();
    cs_lo();
    send_byte(8'h9F);
    sck_cyc(4'h1);
    sck_cyc(4'h2);
    chk("bad_cmd_err", {31'd0, bus.cmd_err}, 32'd1);
    chk("bad_cmd_oe", {31'd0, bus.sqi_data_oe}, 32'd0);
    cs_hi();
    chk("bad_cmd_err_hold", {31'd0, bus.cmd_err}, 32'd1);
    do_read(24'h000100, 16'h0100, 8'hA5, 8'h3C, 2);
    chk("err_cleared", {31'd0, bus.cmd_err}, 32'd0);
    cs_hi();
    do_write(24'h000010, 16'h0010, 8'h12, 8'h30, 3);
    cs_hi();
    chk("abort_oe", {31'd0, bus.sqi_data_oe}, 32'd0);
    do_read(24'h000010, 16'h0010, 8'h12, 8'h00, 1);
    chk("pre_rst_oe", {31'd0, bus.sqi_data_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {31'd0, bus.sqi_data_oe}, 32'd0);
    chk("async_rst_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("async_rst_dout", {28'd0, bus.sqi_data_out}, 32'd0);
    clks(2);
    bus.sqi_cs = 1'b1;
    clks(2);
    rst_n = 1'b1;
    clks(2);
    do_write(24'h000020, 16'h0020, 8'h5A, 8'h00, 2);
    cs_hi();
    clks(4);
    chk("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
